// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - register file access bus between datapath and register file
//
// Signals (widths from ADDR_W / DATA_W):
//   ReadReg1, ReadReg2   read indices (rs, rt)          master -> slave
//   ReadData1, ReadData2 read data (ALU A, ALU B mux)   slave  -> master
//   RegWrite             write enable                   master -> slave
//   WriteReg, WriteData  write index and value          master -> slave
//   DbgReg               debug read index               master -> slave
//   DbgData              debug read data                slave  -> master
//   Ready                array valid after clearing     slave  -> master
interface register_file_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] DbgReg;
    logic [DATA_W-1:0] DbgData;
    logic              Ready;

    modport master (
        output ReadReg1, ReadReg2, RegWrite, WriteReg, WriteData, DbgReg,
        input  ReadData1, ReadData2, DbgData, Ready
    );

    modport slave (
        input  ReadReg1, ReadReg2, RegWrite, WriteReg, WriteData, DbgReg,
        output ReadData1, ReadData2, DbgData, Ready
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 2-read/1-write MIPS register file with post-reset clear sequencer
//
// Ports:
//   Clk    in   clock, all state updates on rising edge
//   Reset  in   synchronous active-high reset; restarts the clear sequence
//   bus    slave modport of register_file_if (read ports, write port,
//          debug read port, Ready)
//
// After reset the sequencer walks registers 1..NREG-1, writing 0 except
// $gp (28) and $sp (29), then enters READY. Reads are combinational and
// forced to zero until READY; register 0 always reads zero.
module register_file #(
    parameter int                NREG    = 32,
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 5,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h7FFF_EFFC,
    parameter logic [DATA_W-1:0] GP_INIT = 32'h1000_8000
) (
    input  logic           Clk,
    input  logic           Reset,
    register_file_if.slave bus
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W-1:0] SP_IDX   = ADDR_W'(29);
    localparam logic [ADDR_W-1:0] GP_IDX   = ADDR_W'(28);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] next_clr_ptr;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] mem [NREG];

    logic              ready;

    function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] idx);
        if (idx == SP_IDX) begin
            return SP_INIT;
        end else if (idx == GP_IDX) begin
            return GP_INIT;
        end else begin
            return '0;
        end
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= ST_CLEAR;
            clr_ptr <= ADDR_W'(1);
        end else begin
            state   <= next_state;
            clr_ptr <= next_clr_ptr;
        end
    end

    // Single array write port shared by the clear sequencer and the
    // datapath; the sequencer owns it for the whole CLEAR state, so datapath
    // writes during clearing are dropped.
    always_comb begin
        next_state   = state;
        next_clr_ptr = clr_ptr;
        wr_en        = 1'b0;
        wr_addr      = clr_ptr;
        wr_data      = '0;

        case (state)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_ptr;
                wr_data = init_value(clr_ptr);
                if (clr_ptr == LAST_IDX) begin
                    next_state = ST_READY;
                end else begin
                    next_clr_ptr = clr_ptr + ADDR_W'(1);
                end
            end
            ST_READY: begin
                wr_en   = bus.RegWrite && (bus.WriteReg != '0);
                wr_addr = bus.WriteReg;
                wr_data = bus.WriteData;
            end
            default: begin
                next_state = ST_CLEAR;
            end
        endcase

        // The reset edge leaves the array untouched.
        if (Reset) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign ready = (state == ST_READY);

    // No write-to-read bypass: a same-cycle bypass would form a
    // combinational loop through the ALU in the single-cycle datapath.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
        if (!ready || idx == '0) begin
            return '0;
        end else begin
            return mem[idx];
        end
    endfunction

    always_comb begin
        bus.ReadData1 = read_port(bus.ReadReg1);
        bus.ReadData2 = read_port(bus.ReadReg2);
        bus.DbgData   = read_port(bus.DbgReg);
        bus.Ready     = ready;
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed vector bench for register_file
module tb_register_file;

    localparam logic [31:0] SP = 32'h7FFF_EFFC;
    localparam logic [31:0] GP = 32'h1000_8000;

    logic clk;
    logic reset;

    register_file_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    register_file dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [4:0]  dbg;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] pre1;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] expd;
    } vec_t;

    vec_t vecs[8];

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.Ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic setrd(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
        bus.ReadReg1 = r1;
        bus.ReadReg2 = r2;
        bus.DbgReg   = d;
        #1;
    endtask

    initial begin
        int n;

        //          rr1 rr2 dbg we  wr  wd              pre1          exp1          exp2          expd
        vecs[0] = '{29, 28, 31, 0,  0,  32'h0,          SP,           SP,           GP,           32'h0};
        vecs[1] = '{20, 5,  30, 0,  0,  32'h0,          32'h0,        32'h0,        32'h0,        32'h0};
        vecs[2] = '{8,  8,  8,  1,  8,  32'hDEADBEEF,   32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3] = '{8,  8,  8,  0,  8,  32'h12345678,   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[4] = '{0,  8,  0,  1,  0,  32'hFFFFFFFF,   32'h0,        32'h0,        32'hDEADBEEF, 32'h0};
        vecs[5] = '{5,  5,  31, 1,  31, 32'hCAFE0001,   32'h0,        32'h0,        32'h0,        32'hCAFE0001};
        vecs[6] = '{29, 31, 8,  1,  29, 32'h00000100,   SP,           32'h00000100, 32'hCAFE0001, 32'hDEADBEEF};
        vecs[7] = '{1,  2,  28, 1,  1,  32'h00000001,   32'h0,        32'h00000001, 32'h0,        GP};

        reset         = 1'b1;
        bus.RegWrite  = 1'b0;
        bus.WriteReg  = '0;
        bus.WriteData = '0;
        setrd(29, 28, 31);

        // Reset held for two edges: outputs forced to zero.
        tick();
        tick();
        chk("reset_ready", 32'(bus.Ready), 32'h0);
        chk("reset_rd1", bus.ReadData1, 32'h0);
        chk("reset_rd2", bus.ReadData2, 32'h0);
        chk("reset_dbg", bus.DbgData, 32'h0);

        // Clear sequence with writes attempted throughout; register 5 is
        // targeted after the sequencer has already passed it.
        reset         = 1'b0;
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd20;
        bus.WriteData = 32'hA5A5A5A5;
        setrd(20, 29, 28);
        n = 0;
        while (!bus.Ready && n < 40) begin
            tick();
            n++;
            if (n == 5) bus.WriteReg = 5'd5;
            if (n == 30) begin
                chk("clear_rd1_zero", bus.ReadData1, 32'h0);
                chk("clear_rd2_zero", bus.ReadData2, 32'h0);
                chk("clear_dbg_zero", bus.DbgData, 32'h0);
                chk("clear_not_ready", 32'(bus.Ready), 32'h0);
            end
        end
        bus.RegWrite = 1'b0;
        chk("clear_latency", 32'(n), 32'd31);

        for (int i = 1; i <= 27; i++) begin
            setrd(5'(i), 5'(i), 5'(i));
            if (bus.ReadData1 !== 32'h0 || bus.ReadData2 !== 32'h0 || bus.DbgData !== 32'h0)
                chk($sformatf("cleared_reg%0d", i), bus.ReadData1 | bus.ReadData2 | bus.DbgData, 32'h0);
        end
        setrd(20, 5, 30);
        chk("clear_write_reg20", bus.ReadData1, 32'h0);
        chk("clear_write_reg5", bus.ReadData2, 32'h0);

        // Table vectors: check old value before the edge, new values after.
        for (int i = 0; i < 8; i++) begin
            bus.RegWrite  = vecs[i].we;
            bus.WriteReg  = vecs[i].wr;
            bus.WriteData = vecs[i].wd;
            setrd(vecs[i].rr1, vecs[i].rr2, vecs[i].dbg);
            chk($sformatf("v%0d_pre_rd1", i), bus.ReadData1, vecs[i].pre1);
            tick();
            bus.RegWrite = 1'b0;
            chk($sformatf("v%0d_rd1", i), bus.ReadData1, vecs[i].exp1);
            chk($sformatf("v%0d_rd2", i), bus.ReadData2, vecs[i].exp2);
            chk($sformatf("v%0d_dbg", i), bus.DbgData, vecs[i].expd);
        end

        // Reset mid-clear restarts the sequence and re-clears written data.
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd8;
        bus.WriteData = 32'h00001111;
        setrd(8, 29, 31);
        tick();
        bus.RegWrite = 1'b0;
        chk("mid_pre_reg8", bus.ReadData1, 32'h00001111);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_clear_not_ready", 32'(bus.Ready), 32'h0);
        reset = 1'b1;
        tick();
        chk("mid_reset_not_ready", 32'(bus.Ready), 32'h0);
        reset = 1'b0;
        wait_ready(n);
        chk("mid_clear_latency", 32'(n), 32'd31);
        chk("mid_reg8", bus.ReadData1, 32'h0);
        chk("mid_reg29", bus.ReadData2, SP);
        chk("mid_reg31", bus.DbgData, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Two-read/one-write 32×32 general-purpose register file for the single-cycle MIPS datapath, directly upstream of the ALU. ReadData1 drives the ALU A input; ReadData2 drives B through the immediate mux. AluResult, or memory data on loads, returns on WriteData. After reset, a sequencer clears the array one register per cycle and loads MIPS pointer defaults. The block signals Ready when the array is valid.

## Interface
- NREG, 32, number of registers; register 0 is hardwired to zero
- DATA_W, 32, register width
- ADDR_W, 5, register index width (log2 NREG)
- SP_INIT, 32'h7FFF_EFFC, value loaded into register 29 ($sp) by the clear sequence
- GP_INIT, 32'h1000_8000, value loaded into register 28 ($gp) by the clear sequence

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- ReadReg1  in  ADDR_W  index for port 1 (rs)
- ReadReg2  in  ADDR_W  index for port 2 (rt)
- ReadData1  out  DATA_W  contents of ReadReg1 (to ALU A)
- ReadData2  out  DATA_W  contents of ReadReg2 (to ALU B mux)
- RegWrite  in  1  write enable
- WriteReg  in  ADDR_W  write index (rd/rt, after RegDst mux)
- WriteData  in  DATA_W  write value (AluResult or load data)
- DbgReg  in  ADDR_W  debug read index (front-panel display)
- DbgData  out  DATA_W  contents of DbgReg
- Ready  out  1  high once the clear sequence completes

## Operation
- States are CLEAR and READY. The pointer ClrPtr is ADDR_W bits wide.
- Reset edge (Reset=1 at a rising edge):
  - state←CLEAR, ClrPtr←1, Ready←0.
  - Array contents are not touched on this edge.
  - Holding Reset keeps the block in this condition.
- CLEAR, Reset=0, each edge:
  - reg[ClrPtr]←init(ClrPtr), where init(29)=SP_INIT, init(28)=GP_INIT, otherwise 0.
  - If ClrPtr==NREG-1: state←READY and Ready←1.
  - Else ClrPtr←ClrPtr+1.
- READY: an edge with RegWrite=1 and WriteReg≠0 stores WriteData into reg[WriteReg]. All other registers hold.
- Writes in CLEAR are ignored regardless of RegWrite.
- A write to index 0 is always discarded. Register 0 reads as 0 in every state.
- Reads are combinational from the array.
  - While Ready=0, ReadData1, ReadData2 and DbgData are forced to 0.
  - While Ready=1, ReadDataN = (ReadRegN==0) ? 0 : reg[ReadRegN]. DbgData follows the same rule.
- There is no write-to-read bypass. Reading a register being written in the same cycle returns the old value. A bypass would close a combinational loop through the ALU in the single-cycle datapath.
- Reset asserted mid-clear or mid-operation restarts the sequence from ClrPtr=1. Partially cleared or previously written contents are overwritten again by the new sequence.
- Before the first reset the array and state are undefined. The top level must pulse Reset at start-up.

## Timing
- Output values under reset: Ready=0; ReadData1, ReadData2 and DbgData all 0.
- Clear latency is NREG-1 = 31 rising edges with Reset=0. Ready rises after the 31st edge.
- Write latency is one edge. The new value appears on the read ports immediately after the capturing edge.
- Read latency is zero cycles (combinational from the indices).
- Index changes during a cycle propagate with no registering.
- RegWrite, WriteReg and WriteData are sampled only at the rising edge. They need no hold beyond the edge.

## Test plan
- Reset clear sequence:
  - Stimulus: Reset=1 for 2 edges, then 0.
  - Ready=0 for exactly 31 edges, then 1.
  - Afterwards, ReadReg1=29 gives 0x7FFFEFFC, ReadReg2=28 gives 0x10008000, DbgReg=31 gives 0, and registers 1..27 read 0.
- Basic write:
  - Stimulus: in READY, RegWrite=1, WriteReg=8, WriteData=0xDEADBEEF, ReadReg1=ReadReg2=8.
  - Before the edge both ports read 0. After the edge both read 0xDEADBEEF.
  - With RegWrite=0, WriteReg=8 and WriteData=0x12345678 on the next edge, both ports still read 0xDEADBEEF.
- Register zero: RegWrite=1, WriteReg=0, WriteData=0xFFFFFFFF, one edge → ReadReg1=0 reads 0x00000000.
- Writes during clear:
  - Stimulus: during CLEAR at ClrPtr≈3, RegWrite=1, WriteReg=20, WriteData=0xA5A5A5A5.
  - Required: read ports show 0 while clearing, and register 20 reads 0 after Ready.
- Reset mid-clear:
  - Stimulus: write 0x1111 to register 8 in READY. Then reset and release, and reassert Reset after 10 clear edges.
  - Required: Ready stays 0, and rises 31 edges after the second release.
  - Register 8 then reads 0 and register 29 reads SP_INIT.
- Debug port independence:
  - Stimulus: write 0xCAFE0001 to register 31, then set DbgReg=31 and ReadReg1=ReadReg2=5.
  - Required: DbgData=0xCAFE0001 while both data ports read 0.
